// File: rtl/apb_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_regfile_pkg
// Brief    : Shared types and helper functions for the APB register file.
// Revision : 1.0 - initial release
// ============================================================================
package apb_regfile_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam int IDX_LSB = 2;
   // Helpers work on a fixed maximum width; callers size-cast in and out.
   localparam int MAX_DW  = 256;
   localparam int MAX_SW  = MAX_DW / 8;

   function automatic logic idx_valid(input logic [63:0] idx, input logic [63:0] num_regs);
      return idx < num_regs;
   endfunction

   function automatic logic [MAX_DW-1:0] apply_strb(input logic [MAX_DW-1:0] old_v,
                                                    input logic [MAX_DW-1:0] wdata,
                                                    input logic [MAX_SW-1:0] strb);
      logic [MAX_DW-1:0] v;
      v = old_v;
      for (int b = 0; b < MAX_SW; b++) begin
         if (strb[b]) v[8*b +: 8] = wdata[8*b +: 8];
      end
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/apb_wait_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : apb_wait_ctrl
// Brief    : APB slave transfer FSM with wait-state counter and registered PREADY.
// Revision : 1.0 - initial release
// ============================================================================
module apb_wait_ctrl
   import apb_regfile_pkg::*;
#(
   parameter int WAIT_STATES = 1
) (
   input  logic clk,
   input  logic rstn,
   input  logic i_psel,
   input  logic i_penable,
   output logic o_pready,
   output logic o_complete,
   output logic o_accept_setup,
   output logic o_resp_load
);

   localparam logic [3:0] c_WAIT = 4'(WAIT_STATES);
   localparam logic       c_ZERO_WAIT = (WAIT_STATES == 0);

   state_t     r_state;
   logic [3:0] r_cnt;
   logic       r_pready;
   logic       w_setup;
   logic       w_accept;
   logic       w_ready_next;

   assign w_setup = i_psel && !i_penable;

   always_comb begin
      w_accept     = 1'b0;
      w_ready_next = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_setup) begin
               w_accept     = 1'b1;
               w_ready_next = c_ZERO_WAIT;
            end
         end
         ACCESS: begin
            if (!r_pready) begin
               if (i_psel && i_penable) begin
                  w_ready_next = ((r_cnt + 4'd1) == c_WAIT);
               end else if (w_setup) begin
                  w_accept     = 1'b1;
                  w_ready_next = c_ZERO_WAIT;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state  <= IDLE;
         r_cnt    <= 4'd0;
         r_pready <= 1'b0;
      end else begin
         r_pready <= w_ready_next;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state <= ACCESS;
                  r_cnt   <= 4'd0;
               end
            end
            ACCESS: begin
               if (r_pready) begin
                  r_state <= IDLE;
               end else if (i_psel && i_penable) begin
                  r_cnt <= r_cnt + 4'd1;
               end else if (!i_psel) begin
                  r_state <= IDLE;   // master abort
               end else begin
                  r_cnt <= 4'd0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_pready       = r_pready;
   assign o_complete     = (r_state == ACCESS) && r_pready;
   assign o_accept_setup = w_accept;
   assign o_resp_load    = w_ready_next;

endmodule
`default_nettype wire

// File: rtl/apb_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module   : apb_regfile_slave
// Brief    : APB register file slave with byte strobes, wait states and errors.
// Revision : 1.0 - initial release
// ============================================================================
module apb_regfile_slave
   import apb_regfile_pkg::*;
#(
   parameter int          ADDR_WIDTH  = 32,
   parameter int          DATA_WIDTH  = 32,
   parameter int          WSTRB_WIDTH = DATA_WIDTH / 8,
   parameter int          NUM_REGS    = 8,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           s_psel,
   input  logic                           s_penable,
   input  logic                           s_pwrite,
   input  logic [ADDR_WIDTH-1:0]          s_paddr,
   input  logic [DATA_WIDTH-1:0]          s_pwdata,
   input  logic [WSTRB_WIDTH-1:0]         s_pstrb,
   output logic [DATA_WIDTH-1:0]          s_prdata,
   output logic                           s_pready,
   output logic                           s_pslverr,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

   localparam int c_IW = ADDR_WIDTH - IDX_LSB;

   logic [c_IW-1:0]       w_idx;
   logic                  w_unused_addr;
   logic                  w_valid;
   logic                  w_err;
   logic                  w_complete;
   logic                  w_accept_setup;
   logic                  w_resp_load;
   logic                  w_commit;
   logic [DATA_WIDTH-1:0] w_rd;
   logic [DATA_WIDTH-1:0] w_new;
   logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
   logic [DATA_WIDTH-1:0] r_prdata;
   logic                  r_pslverr;

   apb_wait_ctrl #(
      .WAIT_STATES (WAIT_STATES)
   ) u_wait_ctrl (
      .clk            (clk),
      .rstn           (rstn),
      .i_psel         (s_psel),
      .i_penable      (s_penable),
      .o_pready       (s_pready),
      .o_complete     (w_complete),
      .o_accept_setup (w_accept_setup),
      .o_resp_load    (w_resp_load)
   );

   assign w_idx         = s_paddr[ADDR_WIDTH-1:IDX_LSB];
   assign w_unused_addr = ^{s_paddr[IDX_LSB-1:0], w_accept_setup};
   assign w_valid       = idx_valid(64'(w_idx), 64'(NUM_REGS));
   assign w_err         = !w_valid || (s_pwrite && (w_idx == '0));
   assign w_commit      = w_complete && s_pwrite && !w_err;

   always_comb begin
      w_rd = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (w_idx == c_IW'(k)) w_rd = w_regs[k];
      end
   end

   assign w_new = DATA_WIDTH'(apply_strb(MAX_DW'(w_rd), MAX_DW'(s_pwdata), MAX_SW'(s_pstrb)));

   // Slot 0 is the constant ID; the remaining slots are writable flops.
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
      if (i == 0) begin : g_id
         assign w_regs[i] = DATA_WIDTH'(ID_VALUE);
      end else begin : g_rw
         logic [DATA_WIDTH-1:0] r_q;
         always_ff @(posedge clk) begin
            if (!rstn) begin
               r_q <= '0;
            end else if (w_commit && (w_idx == c_IW'(i))) begin
               r_q <= w_new;
            end
         end
         assign w_regs[i] = r_q;
      end
      assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = w_regs[i];
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_prdata  <= '0;
         r_pslverr <= 1'b0;
      end else if (w_resp_load) begin
         r_pslverr <= w_err;
         if (w_err) begin
            r_prdata <= '0;
         end else if (!s_pwrite) begin
            r_prdata <= w_rd;
         end
      end else if (w_complete) begin
         r_pslverr <= 1'b0;
      end
   end

   assign s_prdata  = r_prdata;
   assign s_pslverr = r_pslverr;

endmodule
`default_nettype wire

// File: tb/tb_apb_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_regfile_slave
// Brief    : Directed self-checking bench for apb_regfile_slave (WS = 0, 1, 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_regfile_slave;

   localparam logic [31:0] c_ID = 32'hA9B0_0001;

   logic        clk = 1'b0;
   logic        rstn;
   logic        psel0, psel1, psel3;
   logic        penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata0, prdata1, prdata3;
   logic        pready0, pready1, pready3;
   logic        pslverr0, pslverr1, pslverr3;
   logic [255:0] regs0, regs1, regs3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   apb_regfile_slave #(.WAIT_STATES(0)) dut0 (
      .clk(clk), .rstn(rstn), .s_psel(psel0), .s_penable(penable), .s_pwrite(pwrite),
      .s_paddr(paddr), .s_pwdata(pwdata), .s_pstrb(pstrb), .s_prdata(prdata0),
      .s_pready(pready0), .s_pslverr(pslverr0), .regs_o(regs0));

   apb_regfile_slave #(.WAIT_STATES(1)) dut1 (
      .clk(clk), .rstn(rstn), .s_psel(psel1), .s_penable(penable), .s_pwrite(pwrite),
      .s_paddr(paddr), .s_pwdata(pwdata), .s_pstrb(pstrb), .s_prdata(prdata1),
      .s_pready(pready1), .s_pslverr(pslverr1), .regs_o(regs1));

   apb_regfile_slave #(.WAIT_STATES(3)) dut3 (
      .clk(clk), .rstn(rstn), .s_psel(psel3), .s_penable(penable), .s_pwrite(pwrite),
      .s_paddr(paddr), .s_pwdata(pwdata), .s_pstrb(pstrb), .s_prdata(prdata3),
      .s_pready(pready3), .s_pslverr(pslverr3), .regs_o(regs3));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic get_ready(input int w);
      case (w)
         0:       return pready0;
         1:       return pready1;
         default: return pready3;
      endcase
   endfunction

   function automatic logic get_err(input int w);
      case (w)
         0:       return pslverr0;
         1:       return pslverr1;
         default: return pslverr3;
      endcase
   endfunction

   function automatic logic [31:0] get_rdata(input int w);
      case (w)
         0:       return prdata0;
         1:       return prdata1;
         default: return prdata3;
      endcase
   endfunction

   function automatic logic [31:0] get_reg(input int w, input int i);
      case (w)
         0:       return regs0[i*32 +: 32];
         1:       return regs1[i*32 +: 32];
         default: return regs3[i*32 +: 32];
      endcase
   endfunction

   task automatic set_sel(input int w);
      psel0 = (w == 0);
      psel1 = (w == 1);
      psel3 = (w == 3);
   endtask

   task automatic idle();
      @(negedge clk);
      psel0 = 1'b0; psel1 = 1'b0; psel3 = 1'b0; penable = 1'b0;
   endtask

   // Setup on the next falling edge, then access cycles until PREADY is seen.
   // Returns on the falling edge where PREADY=1 (completion happens on the next rise).
   task automatic xfer(input int w, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb,
                       output logic [31:0] rd, output logic err, output int cyc);
      @(negedge clk);
      set_sel(w);
      penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
      cyc = 99; rd = '0; err = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         penable = 1'b1;
         if (get_ready(w)) begin
            cyc = k;
            rd  = get_rdata(w);
            err = get_err(w);
            break;
         end
      end
   endtask

   logic [31:0] rd;
   logic        err;
   int          cyc;

   initial begin
      rstn = 1'b0;
      psel0 = 1'b0; psel1 = 1'b0; psel3 = 1'b0;
      penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      check("rst_pready",  32'(pready1),  32'd0);
      check("rst_pslverr", 32'(pslverr1), 32'd0);
      check("rst_prdata",  prdata1,       32'd0);
      check("rst_reg0_id", get_reg(1, 0), c_ID);
      check("rst_reg1",    get_reg(1, 1), 32'd0);

      // Read ID register, one wait state
      xfer(1, 1'b0, 32'h0, 32'h0, 4'h0, rd, err, cyc);
      check("id_cycles", 32'(cyc), 32'd2);
      check("id_data",   rd,       c_ID);
      check("id_err",    32'(err), 32'd0);
      idle();
      check("id_pready_one_cycle", 32'(pready1), 32'd0);

      // Full-word write then readback
      xfer(1, 1'b1, 32'h4, 32'h1122_3344, 4'hf, rd, err, cyc);
      check("wr1_cycles", 32'(cyc), 32'd2);
      check("wr1_err",    32'(err), 32'd0);
      xfer(1, 1'b0, 32'h4, 32'h0, 4'h0, rd, err, cyc);
      check("rd1_data", rd,            32'h1122_3344);
      check("regs_o_1", get_reg(1, 1), 32'h1122_3344);

      // Partial strobe write
      xfer(1, 1'b1, 32'h4, 32'hFFFF_FFFF, 4'b0101, rd, err, cyc);
      idle();
      check("strb_reg1", get_reg(1, 1), 32'h11FF_33FF);

      // Errors: write to ID, read out of range
      xfer(1, 1'b1, 32'h0, 32'hDEAD_BEEF, 4'hf, rd, err, cyc);
      check("wr_id_err",  32'(err), 32'd1);
      check("wr_id_data", rd,       32'd0);
      xfer(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, err, cyc);
      check("oor_err",  32'(err), 32'd1);
      check("oor_data", rd,       32'd0);
      idle();
      check("err_cleared", 32'(pslverr1), 32'd0);
      check("err_reg0",    get_reg(1, 0), c_ID);
      check("err_reg1",    get_reg(1, 1), 32'h11FF_33FF);

      // Zero-strobe write is legal and has no effect
      xfer(1, 1'b1, 32'h4, 32'h0000_0000, 4'h0, rd, err, cyc);
      check("strb0_err", 32'(err), 32'd0);
      idle();
      check("strb0_reg1", get_reg(1, 1), 32'h11FF_33FF);

      // Zero wait states, back-to-back writes
      xfer(0, 1'b1, 32'h8, 32'hAAAA_5555, 4'hf, rd, err, cyc);
      check("b2b_a_cycles", 32'(cyc), 32'd1);
      xfer(0, 1'b1, 32'hC, 32'h1234_5678, 4'hf, rd, err, cyc);
      check("b2b_b_cycles", 32'(cyc), 32'd1);
      idle();
      check("b2b_pready_low", 32'(pready0), 32'd0);
      check("b2b_reg2", get_reg(0, 2), 32'hAAAA_5555);
      check("b2b_reg3", get_reg(0, 3), 32'h1234_5678);

      // Master abort after one access cycle, WS=3
      @(negedge clk);
      set_sel(3); penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hDEAD_BEEF; pstrb = 4'hf;
      @(negedge clk);
      penable = 1'b1;
      idle();
      repeat (5) @(negedge clk);
      check("abort_pready", 32'(pready3),   32'd0);
      check("abort_reg4",   get_reg(3, 4),  32'd0);
      xfer(3, 1'b1, 32'h14, 32'h0BAD_F00D, 4'hf, rd, err, cyc);
      check("post_abort_cycles", 32'(cyc), 32'd4);
      idle();
      check("post_abort_reg5", get_reg(3, 5), 32'h0BAD_F00D);
      check("post_abort_reg4", get_reg(3, 4), 32'd0);

      // Reset asserted mid-write, WS=1
      @(negedge clk);
      set_sel(1); penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hCAFE_0001; pstrb = 4'hf;
      @(negedge clk);
      penable = 1'b1;
      rstn    = 1'b0;
      @(negedge clk);
      check("rst_mid_pready", 32'(pready1), 32'd0);
      @(negedge clk);
      check("rst_mid_reg4", get_reg(1, 4), 32'd0);
      check("rst_mid_reg1", get_reg(1, 1), 32'd0);
      psel1 = 1'b0; penable = 1'b0;
      rstn  = 1'b1;
      xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, err, cyc);
      check("rst_mid_cycles", 32'(cyc), 32'd2);
      check("rst_mid_read",   rd,       32'd0);
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/apb_regfile_slave.md
Name: apb_regfile_slave

Overview:
- APB slave register file that terminates the transfers produced by the subsystem's APB master stimulus block.
- Decodes the byte address into word registers, applies PSTRB byte-lane writes, returns read data, inserts a configurable number of wait states, and flags errors.
- Exposes all register contents as a flat vector to downstream subsystem logic.
- Register 0 is a read-only ID register.

Parameters:
- ADDR_WIDTH, 32, width of PADDR.
- DATA_WIDTH, 32, width of PWDATA/PRDATA; multiple of 8.
- WSTRB_WIDTH, DATA_WIDTH/8, width of PSTRB.
- NUM_REGS, 8, number of word registers; index 0 is the ID register.
- WAIT_STATES, 1, access-phase cycles with PREADY low before completion; range 0..15.
- ID_VALUE, 32'hA9B0_0001, constant read from register 0.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rstn  input  1  synchronous, active-low reset.
- s_psel  input  1  APB select.
- s_penable  input  1  APB enable (access phase).
- s_pwrite  input  1  1 = write, 0 = read.
- s_paddr  input  ADDR_WIDTH  byte address; register index = s_paddr[ADDR_WIDTH-1:2]; bits [1:0] ignored.
- s_pwdata  input  DATA_WIDTH  write data.
- s_pstrb  input  WSTRB_WIDTH  byte-lane write enables.
- s_prdata  output  DATA_WIDTH  read data, registered.
- s_pready  output  1  transfer completion, registered.
- s_pslverr  output  1  error response, registered; valid only while s_pready=1.
- regs_o  output  NUM_REGS*DATA_WIDTH  flat register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (rstn=0 sampled at a clk edge) sets:
  - state to IDLE;
  - s_pready, s_pslverr to 0;
  - s_prdata to 0;
  - registers 1..NUM_REGS-1 to 0;
  - wait counter to 0.
- Register 0 always reads ID_VALUE.
- Reset asserted mid-transfer aborts the transfer: no write is committed and s_pready is 0 on the next cycle.
- FSM states: IDLE, ACCESS.
- IDLE behaviour:
  - s_pready is 0.
  - A setup phase is s_psel=1 and s_penable=0.
  - On a setup phase: go to ACCESS, cnt<=0, and s_pready<=(WAIT_STATES==0).
  - s_penable=1 without s_psel is ignored; the block stays in IDLE with no side effects.
- ACCESS behaviour:
  - If s_pready=1 in this cycle, the transfer completes on this edge: commit the write (if any), s_pready<=0, s_pslverr<=0, go to IDLE.
  - Else if s_psel=1 and s_penable=1: cnt<=cnt+1 and s_pready<=(cnt+1==WAIT_STATES).
  - Else if s_psel=0 (master abort): go to IDLE, s_pready<=0, nothing committed.
  - Else (s_psel=1, s_penable=0, i.e. a new setup during the wait): restart as if from IDLE.
- Latency:
  - With WAIT_STATES=0, s_pready is high in the first access cycle (one cycle after setup).
  - In general s_pready rises WAIT_STATES cycles later.
  - s_pready stays high for exactly one cycle.
- Response data: s_prdata and s_pslverr are registered on the same edge that sets s_pready=1, using the address and direction sampled at that edge.
  - Read, valid index: s_prdata = register value.
  - Error: s_prdata=0.
  - s_prdata holds its value otherwise.
- Error conditions (s_pslverr=1, no register change):
  - index >= NUM_REGS (read or write);
  - write to index 0.
- Write commit: for each lane b with s_pstrb[b]=1, reg[idx][8b+7:8b] <= s_pwdata[8b+7:8b].
  - Lanes with s_pstrb[b]=0 are unchanged.
  - s_pstrb=0 is a legal write with no effect and no error.
- Back-to-back transfers: after completion the FSM returns to IDLE; the next setup is accepted on the following edge.
- regs_o is driven directly from the register flops, with ID_VALUE in slot 0.

Decomposition:
- Package apb_regfile_pkg holds:
  - state enum {IDLE, ACCESS};
  - localparam IDX_LSB=2;
  - function idx_valid(idx, NUM_REGS);
  - function apply_strb(old, wdata, strb).
- One sub-module, apb_wait_ctrl: the FSM, wait counter and registered PREADY generation, with outputs complete and accept_setup.
- The top level holds address decode, the register array and the response muxing.

Test Plan:
- Reset, then read 0x0 with WAIT_STATES=1 -> s_pready high in the 2nd access cycle, s_prdata=32'hA9B0_0001, s_pslverr=0.
- Write 0x4 data 32'h1122_3344 strb 4'hf, then read 0x4 -> s_prdata=32'h1122_3344; regs_o[63:32]=32'h1122_3344.
- Write 0x4 data 32'hFFFF_FFFF strb 4'b0101 -> reg1=32'h11FF_33FF.
- Write 0x0 and read 0x20 (index 8, NUM_REGS=8) -> s_pslverr=1 with s_pready, s_prdata=0, no register changes.
- WAIT_STATES=0 back-to-back writes to 0x8 and 0xC -> each s_pready one cycle after its setup, both registers updated.
- Abort (drop s_psel after 1 access cycle with WAIT_STATES=3), plus rstn low mid-write -> no commit, s_pready=0, FSM back in IDLE.
